mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (IF) and the data-memory stage (DM) of the pipelined RV32 core.
- Grants at most one access per cycle, with fixed DM priority and a starvation guard for IF.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Drives an IF stall indication consumed by the pipeline hazard logic.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_STARVE, 3, consecutive denied IF request cycles before IF is forced priority; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  IF read request, level.
- if_addr  input  AW  IF read address.
- if_gnt  output  1  IF request accepted this cycle (combinational).
- if_rdata  output  DW  IF read data.
- if_rvalid  output  1  if_rdata valid, 1-cycle pulse.
- dm_req  input  1  DM request, level.
- dm_we  input  1  1 = write, 0 = read.
- dm_addr  input  AW  DM address.
- dm_wdata  input  DW  DM write data.
- dm_gnt  output  1  DM request accepted this cycle (combinational).
- dm_rdata  output  DW  DM read data.
- dm_rvalid  output  1  dm_rdata valid, 1-cycle pulse; never asserted for writes.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid the cycle after a read strobe.
- stall_if  output  1  if_req & ~if_gnt.

Behaviour:
- Reset (rst=1 at edge):
  - starve_cnt=0, rd_pend=0, rd_owner=0.
  - if_rvalid=0, dm_rvalid=0; if_rdata=0, dm_rdata=0 (registered).
  - While rst is high, if_gnt=0, dm_gnt=0, mem_en=0 regardless of requests.
- Arbitration is combinational within the cycle:
  - force_if = (starve_cnt == MAX_STARVE).
  - Only dm_req: dm_gnt=1.
  - Only if_req: if_gnt=1.
  - Both requesting: grant IF if force_if, else grant DM.
  - if_gnt and dm_gnt are never both 1.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr/mem_wdata taken from the granted requester; mem_wdata=0 on IF grant.
  - With no grant, all memory outputs are 0.
- Starvation counter:
  - Increments (saturating at MAX_STARVE) when if_req & ~if_gnt.
  - Clears to 0 on if_gnt or when if_req=0.
- Read response, 1-cycle latency:
  - On a granted read, next edge sets rd_pend=1 and rd_owner = IF(0)/DM(1); otherwise rd_pend=0.
  - While rd_pend=1, mem_rdata is registered into the owner's rdata and that rvalid pulses the following cycle.
  - Total read latency: grant cycle N → rvalid in cycle N+2.
  - The non-owner's rdata holds its previous value.
- Writes: no response; rd_pend is not set.
- Back-to-back grants every cycle are legal.
  - Responses are pipelined in grant order.
  - No bubbles are inserted by the arbiter.
- Requester contract: a requester that is not granted holds req/addr/we/wdata stable until granted. The arbiter does not latch ungranted requests.
- Reset mid-operation: an outstanding read is discarded and no rvalid follows.
- stall_if is purely combinational from if_req and if_gnt.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - conflict_cnt: increments each cycle with if_req & dm_req.
  - force_cnt: increments each cycle IF is granted due to force_if while dm_req=1.
  - Both wrap modulo 2^32 and clear on rst.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- IF-only read: rst released, if_req=1, if_addr=0x10, mem_rdata=0x00500093 → if_gnt=1, mem_addr=0x10, mem_we=0, stall_if=0; if_rvalid=1 with if_rdata=0x00500093 two cycles after grant; dm_rvalid stays 0.
- DM write only: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF → mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; no rvalid follows.
- Simultaneous requests, MAX_STARVE=3, both held high:
  - Cycles 0–2: dm_gnt=1 and stall_if=1.
  - Cycle 3: if_gnt=1.
  - Cycle 4: dm_gnt=1 again, with starve_cnt back at 0.
  - Response owners match grant order.
- Back-to-back reads: DM read of 0x80 then IF read of 0x14 in consecutive cycles → dm_rvalid then if_rvalid in consecutive cycles, each carrying its own mem_rdata.
- Reset mid-read: grant DM read in cycle N, assert rst in N+1 → no dm_rvalid in N+2; all outputs 0 during reset.
- With ARB_PERF_CNT_EN: the 5-cycle contention scenario → conflict_cnt=5, force_cnt=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// requester and the data-memory stage (DM) of the pipelined RV32 core.
//
//   * At most one memory access is granted per cycle.
//   * DM has fixed priority. IF gains priority after MAX_STARVE consecutive
//     cycles of being denied while requesting.
//   * The memory has a 1-cycle read latency. Read data is registered and
//     routed back to the requester that issued the read, so a grant in cycle
//     N yields an rvalid pulse in cycle N+2.
//   * stall_if tells the hazard logic that IF asked but was not served.
//
// Optional build macro: ARB_PERF_CNT_EN
//   When defined, the module adds two free-running 32-bit performance
//   counters as outputs: conflict_cnt and force_cnt.
//
// Parameters:
//   AW          address width
//   DW          data width
//   MAX_STARVE  denied IF cycles before IF is forced ahead of DM (1..15)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic          clk,
    input  logic          rst,

    // instruction fetch requester (read only)
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,

    // data memory requester (read / write)
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_rvalid,

    // shared memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    // pipeline hazard indication
    output logic          stall_if
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   force_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Requester indices; they double as the encoding of the read owner.
    localparam int NREQ   = 2;
    localparam int REQ_IF = 0;
    localparam int REQ_DM = 1;

    // Four bits covers the full legal MAX_STARVE range of 1..15.
    localparam int             SW         = 4;
    localparam logic [SW-1:0]  STARVE_MAX = SW'(MAX_STARVE);

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [SW-1:0] starve_cnt_reg;
    logic [SW-1:0] starve_cnt_next;

    // A read was granted last cycle; mem_rdata is valid this cycle.
    logic          rd_pend_reg;
    logic          rd_pend_next;

    // Who issued that read: 0 = IF, 1 = DM.
    logic          rd_owner_reg;
    logic          rd_owner_next;

    // IF has waited long enough to be placed ahead of DM.
    logic          force_if;

    // ------------------------------------------------------------------------
    // Arbitration: DM wins ties unless IF has starved for MAX_STARVE cycles.
    // Reset masks every grant so the memory sees no traffic during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        force_if = (starve_cnt_reg == STARVE_MAX);
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        if (!rst) begin
            if (if_req && (!dm_req || force_if)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory port drive: steer the granted requester's fields onto the port,
    // zero everything when the port is idle.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            // IF only ever reads, so its write data is held at zero.
            mem_addr  = if_addr;
        end
    end

    // stall_if is purely a function of the IF request and its grant.
    assign stall_if = if_req & ~if_gnt;

    // ------------------------------------------------------------------------
    // Starvation tracking: count consecutive denied IF cycles, saturating at
    // the limit; any IF grant or idle IF cycle restarts the count.
    // ------------------------------------------------------------------------
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (if_gnt || !if_req) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read bookkeeping: remember that a read went out and who owns it. The
    // owner is only updated on a read so the register is quiet otherwise.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_pend_next  = mem_en & ~mem_we;
        rd_owner_next = rd_owner_reg;
        if (mem_en && !mem_we) begin
            rd_owner_next = dm_gnt;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    // ------------------------------------------------------------------------
    // Per-requester response path. Each requester has its own registered
    // rdata/rvalid pair; only the owner of the pending read captures
    // mem_rdata, the other keeps its last value. Because rd_pend/rd_owner
    // are rewritten every cycle, back-to-back reads return in grant order.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        localparam logic OWNER_ID = 1'(gi);

        logic          rvalid_reg;
        logic          rvalid_next;
        logic [DW-1:0] rdata_reg;
        logic [DW-1:0] rdata_next;

        // Capture read data only when this requester owns the pending read.
        always_comb begin
            rvalid_next = rd_pend_reg && (rd_owner_reg == OWNER_ID);
            rdata_next  = rdata_reg;
            if (rvalid_next) begin
                rdata_next = mem_rdata;
            end
        end

        // Response registers; reset drops any in-flight read silently.
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= rvalid_next;
                rdata_reg  <= rdata_next;
            end
        end
    end

    assign if_rvalid = g_resp[REQ_IF].rvalid_reg;
    assign if_rdata  = g_resp[REQ_IF].rdata_reg;
    assign dm_rvalid = g_resp[REQ_DM].rvalid_reg;
    assign dm_rdata  = g_resp[REQ_DM].rdata_reg;

`ifdef ARB_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters, wrapping modulo 2^32.
    //   conflict_cnt : cycles where both requesters asked at once
    //   force_cnt    : cycles where IF won only because it had starved
    // ------------------------------------------------------------------------
    logic [31:0] conflict_cnt_reg;
    logic [31:0] force_cnt_reg;

    // Count contention and forced IF grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_reg <= '0;
            force_cnt_reg    <= '0;
        end else begin
            if (if_req && dm_req) begin
                conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
            end
            if (if_gnt && force_if && dm_req) begin
                force_cnt_reg <= force_cnt_reg + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
    assign force_cnt    = force_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by randomized traffic. A cycle-level reference
// model built from the arbitration rules and a per-cycle history of grants,
// resets and memory read data predicts every DUT output each cycle.
// Build with +define+ARB_PERF_CNT_EN to include the performance counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STARVE = 3;
    localparam int HIST       = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   conflict_cnt;
    logic [31:0]   force_cnt;
`endif

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
        .dm_rvalid(dm_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if)
`ifdef ARB_PERF_CNT_EN
        , .conflict_cnt(conflict_cnt), .force_cnt(force_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Counters and cycle index
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit verbose = 1'b1;

    // Reference model: per-cycle history plus a few abstract quantities.
    int          rd_own_h [HIST];   // -1 none, 0 IF read granted, 1 DM read granted
    bit          rst_h    [HIST];
    logic [31:0] mrd_h    [HIST];
    int          starve_m = 0;      // consecutive denied IF cycles (capped)
    logic [31:0] rdata_m  [2];
    bit          m_if_gnt = 1'b0;
    bit          m_dm_gnt = 1'b0;
    logic [31:0] conf_m   = 0;
    logic [31:0] forc_m   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check every output against the model at the negedge,
    // record this cycle into the history, then move to just after the next
    // rising edge where the caller drives the following cycle's inputs.
    task automatic tick();
        bit          e_if, e_dm, e_en, e_we, forced;
        bit          e_rv [2];
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        forced = (starve_m >= MAX_STARVE);
        e_if   = !rst && if_req && (!dm_req || forced);
        e_dm   = !rst && dm_req && !e_if;
        e_en   = e_if || e_dm;
        e_we   = e_dm && dm_we;
        e_addr = e_dm ? dm_addr : (e_if ? if_addr : 32'd0);
        e_wd   = e_dm ? dm_wdata : 32'd0;

        chk("if_gnt",    32'(if_gnt),    32'(e_if));
        chk("dm_gnt",    32'(dm_gnt),    32'(e_dm));
        chk("mem_en",    32'(mem_en),    32'(e_en));
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      e_wd);
        chk("stall_if",  32'(stall_if),  32'(if_req && !e_if));

        if (cyc >= 1) begin
            for (int o = 0; o < 2; o++) begin
                e_rv[o] = 1'b0;
                if (cyc >= 2 && !rst_h[cyc-1]) begin
                    e_rv[o] = (rd_own_h[cyc-2] == o);
                end
                if (rst_h[cyc-1]) rdata_m[o] = 32'd0;
                else if (e_rv[o]) rdata_m[o] = mrd_h[cyc-1];
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(e_rv[0]));
            chk("if_rdata",  if_rdata,       rdata_m[0]);
            chk("dm_rvalid", 32'(dm_rvalid), 32'(e_rv[1]));
            chk("dm_rdata",  dm_rdata,       rdata_m[1]);
`ifdef ARB_PERF_CNT_EN
            chk("conflict_cnt", conflict_cnt, conf_m);
            chk("force_cnt",    force_cnt,    forc_m);
`endif
        end

        if (verbose && e_en)
            $display("[cyc %0d] %s %s addr=0x%08h wdata=0x%08h",
                     cyc, e_dm ? "DM" : "IF", e_we ? "WR" : "RD", e_addr, e_wd);

        rst_h[cyc]    = rst;
        mrd_h[cyc]    = mem_rdata;
        rd_own_h[cyc] = (e_en && !e_we) ? (e_dm ? 1 : 0) : -1;
        if (rst) begin
            conf_m = 0;
            forc_m = 0;
        end else begin
            if (if_req && dm_req) conf_m = conf_m + 1;
            if (e_if && dm_req)   forc_m = forc_m + 1;
        end
        if (rst)                     starve_m = 0;
        else if (if_req && !e_if)    starve_m = (starve_m < MAX_STARVE) ? starve_m + 1 : MAX_STARVE;
        else                         starve_m = 0;
        m_if_gnt = e_if;
        m_dm_gnt = e_dm;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        rdata_m[0] = 0; rdata_m[1] = 0;
        @(posedge clk);
        #1;

        // Reset: grants and memory strobe suppressed even with requests high
        tick();
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h4; dm_addr = 32'h8;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        tick();
        tick();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        tick();

        // IF-only read of 0x10
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h0;
        #1;
        chk("ifrd_gnt",   32'(if_gnt),   32'd1);
        chk("ifrd_addr",  mem_addr,      32'h10);
        chk("ifrd_we",    32'(mem_we),   32'd0);
        chk("ifrd_stall", 32'(stall_if), 32'd0);
        tick();
        if_req = 1'b0; mem_rdata = 32'h00500093;
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("ifrd_rvalid", 32'(if_rvalid), 32'd1);
        chk("ifrd_rdata",  if_rdata,       32'h00500093);
        chk("ifrd_dmrv",   32'(dm_rvalid), 32'd0);
        tick();

        // DM write of 0xDEADBEEF to 0x40: no response follows
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        #1;
        chk("dmwr_en",    32'(mem_en), 32'd1);
        chk("dmwr_we",    32'(mem_we), 32'd1);
        chk("dmwr_addr",  mem_addr,    32'h40);
        chk("dmwr_wdata", mem_wdata,   32'hDEADBEEF);
        tick();
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0; mem_rdata = 32'h1111_2222;
        tick();
        #1;
        chk("dmwr_no_rv", 32'(dm_rvalid), 32'd0);
        tick();

        // Contention: both held high for five cycles
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
        for (int c = 0; c < 5; c++) begin
            mem_rdata = 32'hA000_0000 + 32'(c);
            #1;
            if (c == 3) begin
                chk("cont_if_gnt", 32'(if_gnt), 32'd1);
            end else begin
                chk("cont_dm_gnt", 32'(dm_gnt), 32'd1);
                chk("cont_stall",  32'(stall_if), 32'd1);
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
        #1;
        chk("perf_conflict", conflict_cnt, 32'd5);
        chk("perf_force",    force_cnt,    32'd1);
`endif
        tick();
        tick();

        // Back-to-back: DM read 0x80 then IF read 0x14
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; mem_rdata = 32'h0;
        tick();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h14; mem_rdata = 32'hCAFE_0080;
        tick();
        if_req = 1'b0; mem_rdata = 32'hBEEF_0014;
        #1;
        chk("b2b_dm_rv",    32'(dm_rvalid), 32'd1);
        chk("b2b_dm_rdata", dm_rdata,       32'hCAFE_0080);
        chk("b2b_if_rv0",   32'(if_rvalid), 32'd0);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("b2b_if_rv",    32'(if_rvalid), 32'd1);
        chk("b2b_if_rdata", if_rdata,       32'hBEEF_0014);
        chk("b2b_dm_rv1",   32'(dm_rvalid), 32'd0);
        tick();

        // Reset mid-read: DM read granted, reset the next cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
        tick();
        dm_req = 1'b0; rst = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        #1;
        chk("rstrd_dm_rv",    32'(dm_rvalid), 32'd0);
        chk("rstrd_dm_rdata", dm_rdata,       32'd0);
        chk("rstrd_if_rdata", if_rdata,       32'd0);
        chk("rstrd_mem_en",   32'(mem_en),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic honouring the hold-until-granted contract
        verbose = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom;
            end
            if (!dm_req || m_dm_gnt) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_rdata = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
